// File: rtl/wired_fcc_exec_if.sv
// Request/response bundle between the FCC issue queue (master) and the FCC exec unit (slave).
interface wired_fcc_exec_if #(
  parameter int unsigned RID_W = 6
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [4:0]       req_cond_i;
  logic [31:0]      req_pc_i;
  logic [27:0]      req_addr_imm_i;
  logic             req_upd_fcc_i;
  logic             req_fcmp_i;
  logic             req_fsel_i;
  logic             req_fclass_i;
  logic             req_beqz_i;
  logic             req_bnez_i;
  logic [31:0]      req_r0_i;
  logic [31:0]      req_r1_i;
  logic [RID_W-1:0] req_wid_i;

  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [31:0]      resp_result_o;
  logic             resp_fcc_o;
  logic             resp_need_jump_o;
  logic [31:0]      resp_target_addr_o;
  logic [4:0]       resp_fp_excp_o;
  logic [RID_W-1:0] resp_wid_o;

  modport master (
    output req_valid_i, req_cond_i, req_pc_i, req_addr_imm_i, req_upd_fcc_i,
           req_fcmp_i, req_fsel_i, req_fclass_i, req_beqz_i, req_bnez_i,
           req_r0_i, req_r1_i, req_wid_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_fcc_o,
           resp_need_jump_o, resp_target_addr_o, resp_fp_excp_o, resp_wid_o
  );

  modport slave (
    input  req_valid_i, req_cond_i, req_pc_i, req_addr_imm_i, req_upd_fcc_i,
           req_fcmp_i, req_fsel_i, req_fclass_i, req_beqz_i, req_bnez_i,
           req_r0_i, req_r1_i, req_wid_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_fcc_o,
           resp_need_jump_o, resp_target_addr_o, resp_fp_excp_o, resp_wid_o
  );
endinterface

// File: rtl/wired_fcc_exec.sv
// FCC execution unit: fcmp/fsel/fclass/bceqz/bcnez with a speculative local FCC,
// two-stage elastic pipeline (S1 compute, S2 output register).
module wired_fcc_exec #(
  parameter int unsigned RID_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic fcc_i,
  wired_fcc_exec_if.slave io
);

  localparam int unsigned OFFS_W = 21;

  typedef struct packed {
    logic [4:0]        cond;
    logic [31:0]       pc;
    logic [OFFS_W-1:0] offs;
    logic              upd;
    logic              fcmp;
    logic              fsel;
    logic              fclass;
    logic              beqz;
    logic              bnez;
    logic [31:0]       r0;
    logic [31:0]       r1;
    logic [RID_W-1:0]  wid;
  } req_t;

  typedef struct packed {
    logic [31:0]      result;
    logic             fcc;
    logic             need_jump;
    logic [31:0]      target;
    logic [4:0]       excp;
    logic [RID_W-1:0] wid;
  } resp_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  // Maps IEEE bit patterns onto an unsigned order (valid for non-NaN, non-zero-pair inputs).
  function automatic logic [31:0] ord_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  function automatic logic [9:0] classify(input logic [31:0] x);
    logic [9:0] m;
    logic       exp_max, exp_zero, man_zero;
    exp_max  = &x[30:23];
    exp_zero = ~|x[30:23];
    man_zero = ~|x[22:0];
    m = '0;
    if (exp_max && !man_zero) m[x[22] ? 1 : 0] = 1'b1;
    else if (exp_max)         m[x[31] ? 2 : 6] = 1'b1;
    else if (exp_zero &&  man_zero) m[x[31] ? 5 : 9] = 1'b1;
    else if (exp_zero)        m[x[31] ? 4 : 8] = 1'b1;
    else                      m[x[31] ? 3 : 7] = 1'b1;
    return m;
  endfunction

  logic  s1_v, s2_v, fcc_q;
  logic  s1_adv, fire;
  req_t  s1_q, req_d;
  resp_t s2_q, s1_res;

  logic unused_imm_hi;
  assign unused_imm_hi = ^io.req_addr_imm_i[27:OFFS_W];

  assign s1_adv         = !s2_v || io.resp_ready_i;
  assign io.req_ready_o = rst_n && !flush_i && (!s1_v || s1_adv);
  assign fire           = io.req_valid_i && io.req_ready_o;

  assign req_d = '{cond: io.req_cond_i, pc: io.req_pc_i, offs: io.req_addr_imm_i[OFFS_W-1:0],
                   upd: io.req_upd_fcc_i, fcmp: io.req_fcmp_i, fsel: io.req_fsel_i,
                   fclass: io.req_fclass_i, beqz: io.req_beqz_i, bnez: io.req_bnez_i,
                   r0: io.req_r0_i, r1: io.req_r1_i, wid: io.req_wid_i};

  // S1 compare: +0/-0 equal, any NaN unordered
  logic un, both_zero, eq, lt, gt, cmp_r, v_flag, taken;
  logic [31:0] offs_ext;
  assign un        = is_nan(s1_q.r0) || is_nan(s1_q.r1);
  assign both_zero = ~|{s1_q.r0[30:0], s1_q.r1[30:0]};
  assign eq        = !un && (both_zero || (s1_q.r0 == s1_q.r1));
  assign lt        = !un && !eq && (ord_key(s1_q.r0) < ord_key(s1_q.r1));
  assign gt        = !un && !eq && !lt;
  assign cmp_r     = (s1_q.cond[3] && un) || (s1_q.cond[2] && eq) ||
                     ((s1_q.cond[1] || s1_q.cond[4]) && lt) || (s1_q.cond[4] && gt);
  assign v_flag    = is_snan(s1_q.r0) || is_snan(s1_q.r1) || (s1_q.cond[0] && un);
  assign taken     = (s1_q.beqz && !fcc_q) || (s1_q.bnez && fcc_q);
  assign offs_ext  = {{(32-OFFS_W-2){s1_q.offs[OFFS_W-1]}}, s1_q.offs, 2'b00};

  // fcc_q already holds any older fcmp that reached S2, so S1 reads it directly
  always_comb begin
    s1_res           = '0;
    s1_res.wid       = s1_q.wid;
    s1_res.fcc       = (s1_q.fcmp && s1_q.upd) ? cmp_r : fcc_q;
    s1_res.need_jump = taken;
    s1_res.target    = taken ? (s1_q.pc + offs_ext) : (s1_q.pc + 32'd4);
    if (s1_q.fcmp)   s1_res.excp   = {v_flag, 4'b0000};
    if (s1_q.fsel)   s1_res.result = fcc_q ? s1_q.r1 : s1_q.r0;
    if (s1_q.fclass) s1_res.result = 32'(classify(s1_q.r0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      fcc_q <= 1'b0;
    end else if (flush_i) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      fcc_q <= fcc_i;
    end else begin
      if (s1_adv) begin
        s2_v <= s1_v;
        if (s1_v && s1_q.fcmp && s1_q.upd) fcc_q <= cmp_r;
      end
      if (!s1_v || s1_adv) s1_v <= fire;
    end
  end

  // Payload registers need no reset; qualified by s1_v/s2_v
  always_ff @(posedge clk) begin
    if (fire)           s1_q <= req_d;
    if (s1_adv && s1_v) s2_q <= s1_res;
  end

  assign io.resp_valid_o       = s2_v;
  assign io.resp_result_o      = s2_q.result;
  assign io.resp_fcc_o         = s2_q.fcc;
  assign io.resp_need_jump_o   = s2_q.need_jump;
  assign io.resp_target_addr_o = s2_q.target;
  assign io.resp_fp_excp_o     = s2_q.excp;
  assign io.resp_wid_o         = s2_q.wid;

endmodule

// File: tb/tb_wired_fcc_exec.sv
// Scoreboard bench for wired_fcc_exec: real-valued reference model, directed and random stimulus.
module tb_wired_fcc_exec;
  localparam int unsigned RID_W = 6;
  localparam int OP_NOP = 0, OP_FCMP = 1, OP_FSEL = 2, OP_FCLASS = 3, OP_BEQZ = 4, OP_BNEZ = 5;

  typedef struct {
    logic [31:0]      result;
    logic             fcc;
    logic             nj;
    logic [31:0]      tgt;
    logic [4:0]       ex;
    logic [RID_W-1:0] wid;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, flush, fcc_in;
  always #5 clk = ~clk;

  wired_fcc_exec_if #(.RID_W(RID_W)) bus ();
  wired_fcc_exec #(.RID_W(RID_W)) dut (.clk(clk), .rst_n(rst_n), .flush_i(flush), .fcc_i(fcc_in), .io(bus));

  exp_t sb_q[$];
  exp_t rx_log[$];
  int   rx_cyc[$];
  int   total = 0, bad = 0, cyc = 0;
  bit   model_fcc = 1'b0;
  bit   bp_on = 1'b0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] pk(input exp_t e);
    return {51'b0, e.result, e.fcc, e.nj, e.tgt, e.ex, e.wid};
  endfunction

  function automatic bit f_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction

  // Numeric value of a single; infinities map beyond the finite range
  function automatic real to_real(input logic [31:0] x);
    int  e;
    real m, v;
    e = int'(x[30:23]);
    m = real'(x[22:0]);
    if (e == 255)    v = 1.0e39;
    else if (e == 0) v = m * (2.0 ** (-149));
    else             v = (m + 8388608.0) * (2.0 ** (e - 150));
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] fclass_ref(input logic [31:0] x);
    int idx;
    bit s;
    s = x[31];
    if (f_nan(x))                           idx = x[22] ? 1 : 0;
    else if (x[30:23] == 8'hFF)             idx = s ? 2 : 6;
    else if (x[30:0] == 0)                  idx = s ? 5 : 9;
    else if (x[30:23] == 0)                 idx = s ? 4 : 8;
    else                                    idx = s ? 3 : 7;
    return 32'd1 << idx;
  endfunction

  function automatic exp_t model(input int op, input logic [4:0] cond, input logic [31:0] pc,
                                 input logic [27:0] imm, input logic upd, input logic [31:0] a,
                                 input logic [31:0] b, input logic [RID_W-1:0] wid);
    exp_t   e;
    real    va, vb;
    bit     un, eq, lt, gt, r, snan;
    longint off, t;
    e.result = 0; e.nj = 0; e.ex = 0; e.wid = wid; e.tgt = pc + 32'd4;
    case (op)
      OP_FCMP: begin
        un = f_nan(a) || f_nan(b);
        va = to_real(a); vb = to_real(b);
        eq = !un && (va == vb);
        lt = !un && (va < vb);
        gt = !un && (va > vb);
        r  = (cond[3] && un) || (cond[2] && eq) || ((cond[1] || cond[4]) && lt) || (cond[4] && gt);
        snan = (f_nan(a) && !a[22]) || (f_nan(b) && !b[22]);
        if (snan || (cond[0] && un)) e.ex = 5'b10000;
        if (upd) model_fcc = r;
      end
      OP_FSEL:   e.result = model_fcc ? b : a;
      OP_FCLASS: e.result = fclass_ref(a);
      OP_BEQZ, OP_BNEZ: begin
        e.nj = (op == OP_BEQZ) ? !model_fcc : model_fcc;
        if (e.nj) begin
          off = longint'(imm[20:0]);
          if (off >= 1048576) off -= 2097152;
          t = longint'(pc) + off * 4;
          e.tgt = t[31:0];
        end
      end
      default: ;
    endcase
    e.fcc = model_fcc;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) if (bp_on) begin
    #1 bus.resp_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Monitor: held responses are compared every cycle; a handshake pops the scoreboard
  always @(negedge clk) begin
    exp_t a;
    if (rst_n && bus.resp_valid_o) begin
      a.result = bus.resp_result_o; a.fcc = bus.resp_fcc_o; a.nj = bus.resp_need_jump_o;
      a.tgt = bus.resp_target_addr_o; a.ex = bus.resp_fp_excp_o; a.wid = bus.resp_wid_o;
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got wid=%0h with empty scoreboard", a.wid);
      end else begin
        check(bus.resp_ready_i ? "resp" : "resp_held", pk(a), pk(sb_q[0]));
        if (bus.resp_ready_i) begin
          void'(sb_q.pop_front());
          rx_log.push_back(a);
          rx_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input int op, input logic [4:0] cond, input logic [31:0] pc, input logic [27:0] imm,
                       input logic upd, input logic [31:0] a, input logic [31:0] b,
                       input logic [RID_W-1:0] wid, output int waited);
    bus.req_cond_i = cond; bus.req_pc_i = pc; bus.req_addr_imm_i = imm; bus.req_upd_fcc_i = upd;
    bus.req_fcmp_i = (op == OP_FCMP); bus.req_fsel_i = (op == OP_FSEL); bus.req_fclass_i = (op == OP_FCLASS);
    bus.req_beqz_i = (op == OP_BEQZ); bus.req_bnez_i = (op == OP_BNEZ);
    bus.req_r0_i = a; bus.req_r1_i = b; bus.req_wid_i = wid;
    bus.req_valid_i = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready_o) break;
      waited++;
      if (waited >= 200) begin
        total++; bad++;
        $display("FAIL issue_timeout: ready=%0b after %0d cycles want 1", bus.req_ready_o, waited);
        break;
      end
    end
    if (waited < 200) sb_q.push_back(model(op, cond, pc, imm, upd, a, b, wid));
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] r;
    logic        s;
    logic [31:0] pool [4];
    r = $urandom(); s = r[31];
    pool[0] = 32'h3F800000; pool[1] = 32'h40000000; pool[2] = 32'h40400000; pool[3] = 32'h00000000;
    case ($urandom_range(0, 9))
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 1'b1, r[21:0]};
      3: return {s, 8'hFF, 1'b0, r[21:1], 1'b1};
      4: return {s, 8'h00, r[22:1], 1'b1};
      5, 6: return {s, pool[$urandom_range(0, 3)][30:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    int w, base, w2;
    logic [31:0] a, b;
    rst_n = 1'b0; flush = 1'b0; fcc_in = 1'b0;
    bus.req_valid_i = 0; bus.req_cond_i = 0; bus.req_pc_i = 0; bus.req_addr_imm_i = 0;
    bus.req_upd_fcc_i = 0; bus.req_fcmp_i = 0; bus.req_fsel_i = 0; bus.req_fclass_i = 0;
    bus.req_beqz_i = 0; bus.req_bnez_i = 0; bus.req_r0_i = 0; bus.req_r1_i = 0; bus.req_wid_i = 0;
    bus.resp_ready_i = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 128'(bus.resp_valid_o), 128'(0));
    check("reset_ready", 128'(bus.req_ready_o), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 128'(bus.req_ready_o), 128'(1));
    check("post_reset_valid", 128'(bus.resp_valid_o), 128'(0));

    // Flush loads fcc_i; a request presented with flush is dropped
    @(posedge clk); #1;
    flush = 1'b1; fcc_in = 1'b1; bus.req_valid_i = 1'b1; bus.req_fcmp_i = 1'b1; bus.req_upd_fcc_i = 1'b1;
    @(negedge clk);
    check("flush_ready", 128'(bus.req_ready_o), 128'(0));
    @(posedge clk); #1;
    flush = 1'b0; bus.req_valid_i = 1'b0; bus.req_fcmp_i = 1'b0; model_fcc = 1'b1;
    base = rx_log.size();
    issue(OP_BNEZ, 0, 32'h00001000, 28'h10, 0, 0, 0, 6'h01, w);
    drain();
    check("flush_bcnez_nj", 128'(rx_log[base].nj), 128'(1));
    check("flush_bcnez_tgt", 128'(rx_log[base].tgt), 128'(32'h00001040));

    // fcmp conditions
    base = rx_log.size();
    issue(OP_FCMP, 5'h02, 32'h100, 0, 1, 32'h3F800000, 32'h40000000, 6'h02, w);
    issue(OP_FCMP, 5'h14, 32'h104, 0, 1, 32'h7FC00000, 32'h3F800000, 6'h03, w);
    issue(OP_FCMP, 5'h03, 32'h108, 0, 1, 32'h7FC00000, 32'h3F800000, 6'h04, w);
    drain();
    check("clt_fcc", 128'(rx_log[base].fcc), 128'(1));
    check("clt_excp", 128'(rx_log[base].ex), 128'(0));
    check("cor_fcc", 128'(rx_log[base+1].fcc), 128'(0));
    check("cor_excp", 128'(rx_log[base+1].ex), 128'(0));
    check("slt_excp", 128'(rx_log[base+2].ex), 128'(5'b10000));

    // Back-to-back fcmp -> fsel
    base = rx_log.size();
    issue(OP_FCMP, 5'h04, 32'h200, 0, 1, 32'h40400000, 32'h40400000, 6'h05, w);
    issue(OP_FSEL, 0, 32'h204, 0, 0, 32'hAAAA0000, 32'h5555FFFF, 6'h06, w2);
    drain();
    check("fsel_no_stall", 128'(w2), 128'(0));
    check("fsel_result", 128'(rx_log[base+1].result), 128'(32'h5555FFFF));
    check("fsel_spacing", 128'(rx_cyc[base+1] - rx_cyc[base]), 128'(1));

    // Branch targets with fcc=0
    base = rx_log.size();
    issue(OP_FCMP, 5'h02, 32'h300, 0, 1, 32'h40000000, 32'h3F800000, 6'h07, w);
    issue(OP_BEQZ, 0, 32'h1C000000, 28'h01FFFFF, 0, 0, 0, 6'h08, w);
    issue(OP_BNEZ, 0, 32'h1C000000, 28'h01FFFFF, 0, 0, 0, 6'h09, w);
    drain();
    check("bceqz_nj", 128'(rx_log[base+1].nj), 128'(1));
    check("bceqz_tgt", 128'(rx_log[base+1].tgt), 128'(32'h1BFFFFFC));
    check("bcnez_nj", 128'(rx_log[base+2].nj), 128'(0));
    check("bcnez_tgt", 128'(rx_log[base+2].tgt), 128'(32'h1C000004));

    // fclass
    base = rx_log.size();
    issue(OP_FCLASS, 0, 0, 0, 0, 32'h80000000, 32'h80000000, 6'h0A, w);
    issue(OP_FCLASS, 0, 0, 0, 0, 32'h7F800001, 32'h7F800001, 6'h0B, w);
    issue(OP_FCLASS, 0, 0, 0, 0, 32'h00000001, 32'h00000001, 6'h0C, w);
    issue(OP_NOP, 0, 32'h400, 0, 0, 32'h1, 32'h2, 6'h0D, w);
    drain();
    check("fclass_negzero", 128'(rx_log[base].result), 128'(32'h20));
    check("fclass_snan", 128'(rx_log[base+1].result), 128'(32'h1));
    check("fclass_possub", 128'(rx_log[base+2].result), 128'(32'h100));
    check("nop_result", 128'(rx_log[base+3].result), 128'(0));

    // Back-pressure: two held, third refused until release
    base = rx_log.size();
    bus.resp_ready_i = 1'b0;
    issue(OP_FCLASS, 0, 0, 0, 0, 32'h3F800000, 0, 6'h11, w);
    issue(OP_FSEL, 0, 0, 0, 0, 32'h12345678, 32'h9ABCDEF0, 6'h22, w);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready", 128'(bus.req_ready_o), 128'(0));
      check("bp_valid", 128'(bus.resp_valid_o), 128'(1));
    end
    @(posedge clk); #1 bus.resp_ready_i = 1'b1;
    issue(OP_BEQZ, 0, 32'h500, 28'h4, 0, 0, 0, 6'h33, w);
    drain();
    check("bp_wid0", 128'(rx_log[base].wid), 128'(6'h11));
    check("bp_wid1", 128'(rx_log[base+1].wid), 128'(6'h22));
    check("bp_wid2", 128'(rx_log[base+2].wid), 128'(6'h33));

    // Flush mid-stall kills everything in flight
    base = rx_log.size();
    bus.resp_ready_i = 1'b0;
    issue(OP_FCMP, 5'h04, 0, 0, 1, 32'h3F800000, 32'h3F800000, 6'h2A, w);
    issue(OP_FSEL, 0, 0, 0, 0, 32'h1, 32'h2, 6'h2B, w);
    fcc_in = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; sb_q.delete(); model_fcc = 1'b0; bus.resp_ready_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("flush_no_resp", 128'(bus.resp_valid_o), 128'(0));
    end
    check("flush_log_count", 128'(rx_log.size()), 128'(base));
    @(posedge clk); #1;
    issue(OP_BEQZ, 0, 32'h600, 28'h8, 0, 0, 0, 6'h2C, w);
    drain();

    // Random traffic with random back-pressure
    bp_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a = rnd_fp();
      b = ($urandom_range(0, 4) == 0) ? a : rnd_fp();
      issue($urandom_range(0, 5), 5'($urandom()), $urandom() & 32'hFFFFFFFC, 28'($urandom()),
            1'($urandom()), a, b, RID_W'(i), w);
    end
    bp_on = 1'b0;
    @(posedge clk); #2 bus.resp_ready_i = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wired_fcc_exec.md
Name: wired_fcc_exec

Overview:
- Floating-point condition-code (FCC) execution unit.
- Responder end of the FCC issue-queue request/response interface. Accepts in-order requests, one per cycle: fcmp, fsel, fclass, bceqz, bcnez.
- Keeps a speculative local FCC and returns results toward the issue queue's commit FIFO.
- Two-stage elastic pipeline (S1 compute, S2 output register).

Parameters:
RID_W, 6, width of ROB id (wid)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
flush_i  in  1  backend flush; kill all in-flight ops
fcc_i  in  1  backend-committed correct FCC, loaded on flush
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_cond_i  in  5  fcmp condition code
req_pc_i  in  32  instruction PC
req_addr_imm_i  in  28  immediate; branch offs21 = addr_imm[20:0]
req_upd_fcc_i  in  1  op writes FCC
req_fcmp_i / req_fsel_i / req_fclass_i / req_beqz_i / req_bnez_i  in  1 each  one-hot op select
req_r0_i, req_r1_i  in  32 each  single-precision operands
req_wid_i  in  RID_W  destination ROB id
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed when valid&ready
resp_result_o  out  32  data result
resp_fcc_o  out  1  FCC value after this op
resp_need_jump_o  out  1  branch taken
resp_target_addr_o  out  32  branch target, or pc+4
resp_fp_excp_o  out  5  flags {V,Z,O,U,I}
resp_wid_o  out  RID_W  echoed wid

Behaviour:
Reset and flush:
- Reset: resp_valid_o=0, s1/s2 valid=0, fcc_q=0. Data outputs are don't-care while invalid.
- req_ready_o = !s1_v | s1_adv; s1_adv = !s2_v | resp_ready_i. Fully combinational; never 1 during reset.
- flush_i (sync): s1_v=s2_v=0, fcc_q<=fcc_i, req_ready_o forced 0 that cycle. Requests presented with flush_i are dropped. A flush on the same edge as an accept wins.

Pipeline and latency:
- S1 captures the request on fire. S2 captures the S1 result when s1_adv.
- Latency: resp_valid_o rises 2 cycles after fire.
- Throughput: 1/cycle.
- Back-pressure: holding resp_ready_i=0 stalls both stages. Payload stays stable while resp_valid_o&!resp_ready_i.

Local FCC (fcc_q):
- Updated when an S1 fcmp with upd_fcc advances to S2.
- fsel/branch in S1 read the effective value: the fcc of an S2 fcmp that has not yet been written to fcc_q, else fcc_q. Back-to-back dependency therefore costs no stall.
- resp_fcc_o = fcc after the op (unchanged for non-fcmp).

fcmp:
- Classify operands: UN (either NaN), EQ (incl. +0==-0), LT, GT.
- Compare result r = (c3&UN) | (c2&EQ) | ((c1|c4)&LT) | (c4&GT).
- result=0; fcc=r.
- V set if either operand is sNaN, or c0=1 and either operand is NaN. Other flags 0.

fsel:
- result = fcc ? r1 : r0.

fclass:
- result = 10-bit one-hot mask, zero-extended: bit0 sNaN, 1 qNaN, 2 -inf, 3 -normal, 4 -subnormal, 5 -zero, 6 +inf, 7 +normal, 8 +subnormal, 9 +zero.

Branches:
- bceqz taken iff fcc==0; bcnez taken iff fcc==1.
- need_jump=taken.
- target = taken ? pc + (sext(offs21)<<2) : pc+4, mod 2^32.
- Non-branch ops: need_jump=0, target=pc+4.

Other:
- No op bit set: NOP; result=0, flags=0, response still produced.

Test Plan:
- Reset and flush state: rst_n=0 for 2 cycles -> resp_valid_o=0, req_ready_o=1 after release. Then flush with fcc_i=1 followed by bcnez -> need_jump=1.
- fcmp conditions: fcmp cond=0x2 (CLT) on 1.0 vs 2.0 with upd_fcc -> fcc=1, fp_excp=0. cond=0x14 (COR) on qNaN vs 1.0 -> fcc=0, V=0. cond=0x3 (SLT) on qNaN -> V=1 (fp_excp=5'b10000).
- FCC forwarding: fcmp CEQ on 3.0 vs 3.0 (upd_fcc) back-to-back with fsel r0=0xAAAA0000, r1=0x5555FFFF -> result 0x5555FFFF, no bubble.
- Branch targets: bceqz pc=0x1C000000, offs21=0x1FFFFF (-1), fcc=0 -> need_jump=1, target=0x1BFFFFFC. bcnez same -> need_jump=0, target=0x1C000004.
- fclass: operands 0x80000000 -> 0x20; 0x7F800001 -> 0x1; 0x00000001 -> 0x100.
- Back-pressure and flush mid-stall: resp_ready_i=0 with 3 issues -> 2 held, req_ready_o=0, payload stable. Then release -> in-order delivery, wid preserved. Flush mid-stall -> no responses emitted.
